otbn_imem_arbiter: RTL and testbench
====================================

Name: otbn_imem_arbiter

Overview:
- Owns the single IMEM port and shares it between three requesters, in priority order:
  - the secure-wipe sweep engine (internal);
  - instruction fetch/prefetch;
  - host bus accesses.
- Sequences a full-memory wipe and routes each read response to the requester that issued it.
- Moves to a terminal LOCKED state on a fatal error.
- Sits between otbn_instruction_fetch, the host bus adapter and the IMEM macro.

Parameters:
- ImemSizeByte, 4096, IMEM size in bytes.
- ImemAddrWidth, vbits(ImemSizeByte), byte-address width (localparam).
- ImemWords, ImemSizeByte/4, number of 39-bit words (localparam).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- busy_i  in  1  OTBN executing; host accesses are refused.
- fatal_i  in  1  fatal error; lock the arbiter.
- wipe_start_i  in  1  pulse: start the IMEM wipe sweep.
- wipe_data_i  in  39  fill data (URND plus recomputed integrity) used for wipe writes.
- wipe_active_o  out  1  sweep in progress.
- wipe_done_o  out  1  one-cycle pulse when the sweep completes.
- locked_o  out  1  arbiter is in LOCKED.
- fetch_req_i  in  1  fetch read request.
- fetch_addr_i  in  ImemAddrWidth  fetch byte address.
- fetch_rvalid_o  out  1  fetch read data valid.
- fetch_rdata_o  out  39  fetch read data.
- host_req_i  in  1  host request.
- host_we_i  in  1  host write.
- host_addr_i  in  ImemAddrWidth  host byte address.
- host_wdata_i  in  39  host write data.
- host_gnt_o  out  1  host request accepted this cycle.
- host_rvalid_o  out  1  host response valid (reads and writes).
- host_rdata_o  out  39  host read data (zero on error).
- host_err_o  out  1  host response is an error.
- mem_req_o  out  1  IMEM request.
- mem_we_o  out  1  IMEM write.
- mem_addr_o  out  ImemAddrWidth  IMEM byte address; bits [1:0] are always 0.
- mem_wdata_o  out  39  IMEM write data.
- mem_rdata_i  in  39  IMEM read data.
- mem_rvalid_i  in  1  IMEM read valid, one cycle after a read request.

Behaviour:
- Reset values:
  - all outputs are 0;
  - state is IDLE, owner_q is OwnerNone, wipe counter is 0.
- States and transitions:
  - IDLE -> WIPE on wipe_start_i.
  - WIPE -> IDLE after the write to word ImemWords-1 is issued.
  - Any state -> LOCKED on fatal_i. LOCKED is left only by reset.
- Arbitration in IDLE, evaluated each cycle:
  - fetch_req_i wins: mem read at fetch_addr_i, owner_q <= OwnerFetch.
  - Otherwise, if host_req_i and !busy_i:
    - host_gnt_o=1 and the mem access is forwarded;
    - reads set owner_q <= OwnerHost;
    - writes produce host_rvalid_o one cycle later with err=0.
  - host_req_i while busy_i:
    - host_gnt_o=1, no mem access;
    - next cycle host_rvalid_o=1, host_err_o=1, host_rdata_o=0.
  - host_req_i together with fetch_req_i while !busy_i: host_gnt_o=0 and the host retries.
- Response routing:
  - fetch_rvalid_o = mem_rvalid_i & owner_q==OwnerFetch.
  - host_rvalid_o = mem_rvalid_i & owner_q==OwnerHost.
  - Read data passes through unmodified. Integrity is checked by consumers, not here.
  - owner_q returns to OwnerNone in any cycle with no read issued.
- WIPE:
  - Each cycle: mem_req_o=1, mem_we_o=1, mem_addr_o={cnt,2'b00}, mem_wdata_o=wipe_data_i; cnt increments.
  - The sweep takes exactly ImemWords cycles.
  - wipe_done_o pulses in the cycle after the last write.
  - fetch_req_i is ignored and fetch_rvalid_o stays 0.
  - Host requests are granted with an error response, as in the busy case.
  - wipe_start_i during WIPE is ignored; the sweep does not restart.
- LOCKED:
  - mem_req_o=0, locked_o=1, fetch_rvalid_o=0.
  - Every host request is granted with an error response.
  - A pending read response in the cycle of lock is dropped; the host still gets rvalid+err for any granted request.
- fatal_i mid-WIPE: the sweep aborts immediately and wipe_done_o never pulses.
- Counter wrap: cnt is sized $clog2(ImemWords) and never wraps, because the transition to IDLE happens at the last word.
- Asynchronous reset mid-operation: returns to IDLE; no response is owed.

Decomposition:
- otbn_pkg holds:
  - typedef imem_arb_state_e {ImemArbIdle, ImemArbWipe, ImemArbLocked}, sparse-encoded;
  - typedef imem_owner_e {OwnerNone, OwnerFetch, OwnerHost}.
- State register uses prim_sparse_fsm_flop; an illegal encoding goes to LOCKED.
- No sub-module; the sweep counter is inline.

Test Plan:
- Fetch and host read same cycle, !busy, addr 0x10/0x20 -> mem_addr_o=0x10, host_gnt_o=0; next cycle fetch_rvalid_o=1 with the mem data; host granted the following cycle.
- busy_i=1, host read 0x40 -> host_gnt_o=1, mem_req_o=0; next cycle host_rvalid_o=1, host_err_o=1, host_rdata_o=0.
- ImemSizeByte=64, wipe_start_i -> 16 consecutive writes to addr 0x00..0x3C; wipe_done_o pulses in cycle 17; fetch requests during the sweep get no rvalid.
- fatal_i at sweep word 5 -> mem_req_o=0 next cycle, locked_o=1, no wipe_done_o; later host write gets rvalid+err.
- Host write 0x8 data 0x1_2345_6789 while idle -> mem_we_o=1 with that data; next cycle host_rvalid_o=1, host_err_o=0.
- Reset asserted mid-sweep, then released -> all outputs 0, state IDLE; a new wipe_start_i sweeps from word 0.

Source files
------------

// File: rtl/otbn_pkg.sv
// Shared types for the OTBN IMEM arbiter: sparse FSM encoding and
// response-owner tags.
package otbn_pkg;

  // Width of one IMEM word: 32 data bits plus 7 integrity bits.
  localparam int ImemDataWidth = 39;

  // The state encodings are kept at least 3 bits apart from each other.
  // A single flipped bit therefore cannot turn one legal state into another.
  typedef enum logic [4:0] {
    ImemArbIdle   = 5'b10100,
    ImemArbWipe   = 5'b01110,
    ImemArbLocked = 5'b11011
  } imem_arb_state_e;

  // Records which requester issued the read that returns in the next cycle.
  typedef enum logic [1:0] {
    OwnerNone  = 2'd0,
    OwnerFetch = 2'd1,
    OwnerHost  = 2'd2
  } imem_owner_e;

endpackage

// File: rtl/otbn_imem_arbiter.sv
// OTBN IMEM arbiter.
// Shares the single IMEM port between the wipe sweep, instruction fetch and
// host bus, in that priority order. Read responses are routed back to their
// issuer. A fatal error locks the arbiter until reset.
module otbn_imem_arbiter
  import otbn_pkg::*;
#(
  parameter  int ImemSizeByte  = 4096,
  localparam int ImemAddrWidth = $clog2(ImemSizeByte),
  localparam int ImemWords     = ImemSizeByte / 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     busy_i,
  input  logic                     fatal_i,
  input  logic                     wipe_start_i,
  input  logic [38:0]              wipe_data_i,
  output logic                     wipe_active_o,
  output logic                     wipe_done_o,
  output logic                     locked_o,
  input  logic                     fetch_req_i,
  input  logic [ImemAddrWidth-1:0] fetch_addr_i,
  output logic                     fetch_rvalid_o,
  output logic [38:0]              fetch_rdata_o,
  input  logic                     host_req_i,
  input  logic                     host_we_i,
  input  logic [ImemAddrWidth-1:0] host_addr_i,
  input  logic [38:0]              host_wdata_i,
  output logic                     host_gnt_o,
  output logic                     host_rvalid_o,
  output logic [38:0]              host_rdata_o,
  output logic                     host_err_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ImemAddrWidth-1:0] mem_addr_o,
  output logic [38:0]              mem_wdata_o,
  input  logic [38:0]              mem_rdata_i,
  input  logic                     mem_rvalid_i
);

  localparam int CntWidth = $clog2(ImemWords);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(ImemWords - 1);

  imem_arb_state_e     state_q, state_d;
  imem_owner_e         owner_q, owner_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                wipe_done_q, wipe_done_d;
  logic                host_err_q, host_err_d;
  logic                host_wack_q, host_wack_d;
  logic                host_rd_ok, host_rd_drop;

  // IMEM is word-addressed, so the byte-offset bits of the requesters are
  // deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr_i[1:0], host_addr_i[1:0]};

  // Next-state logic: arbitration, wipe sweep sequencing and lock handling.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    owner_d     = OwnerNone;
    cnt_d       = cnt_q;
    wipe_done_d = 1'b0;
    host_err_d  = 1'b0;
    host_wack_d = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    host_gnt_o  = 1'b0;

    unique case (state_q)
      ImemArbIdle: begin
        if (host_req_i && busy_i) begin
          // The host is refused while OTBN runs, but it always gets a
          // response.
          host_gnt_o = 1'b1;
          host_err_d = 1'b1;
        end
        if (fetch_req_i) begin
          mem_req_o  = 1'b1;
          mem_addr_o = {fetch_addr_i[ImemAddrWidth-1:2], 2'b00};
          owner_d    = OwnerFetch;
        end else if (host_req_i && !busy_i) begin
          host_gnt_o  = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = host_we_i;
          mem_addr_o  = {host_addr_i[ImemAddrWidth-1:2], 2'b00};
          mem_wdata_o = host_we_i ? host_wdata_i : '0;
          if (host_we_i) begin
            host_wack_d = 1'b1;
          end else begin
            owner_d = OwnerHost;
          end
        end
        if (wipe_start_i) begin
          state_d = ImemArbWipe;
          cnt_d   = '0;
        end
      end

      ImemArbWipe: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {cnt_q, 2'b00};
        mem_wdata_o = wipe_data_i;
        if (host_req_i) begin
          host_gnt_o = 1'b1;
          host_err_d = 1'b1;
        end
        if (cnt_q == LastCnt) begin
          state_d     = ImemArbIdle;
          cnt_d       = '0;
          wipe_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end

      ImemArbLocked: begin
        if (host_req_i) begin
          host_gnt_o = 1'b1;
          host_err_d = 1'b1;
        end
      end

      // An illegal encoding is treated as a fault.
      default: state_d = ImemArbLocked;
    endcase

    // A fatal error overrides everything. An ongoing sweep is abandoned and
    // its completion is never reported.
    if (fatal_i) begin
      state_d     = ImemArbLocked;
      cnt_d       = '0;
      wipe_done_d = 1'b0;
    end
  end

  // Response routing.
  // Once locked, a pending host read is answered with an error instead of
  // data. A pending fetch read is discarded.
  always_comb begin
    host_rd_ok     = mem_rvalid_i && (owner_q == OwnerHost) && (state_q != ImemArbLocked);
    host_rd_drop   = (owner_q == OwnerHost) && (state_q == ImemArbLocked);
    fetch_rvalid_o = mem_rvalid_i && (owner_q == OwnerFetch) && (state_q != ImemArbLocked);
    fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : '0;
    host_rvalid_o  = host_rd_ok || host_rd_drop || host_err_q || host_wack_q;
    host_err_o     = host_err_q || host_rd_drop;
    host_rdata_o   = host_rd_ok ? mem_rdata_i : '0;
    wipe_active_o  = (state_q == ImemArbWipe);
    locked_o       = (state_q == ImemArbLocked);
    wipe_done_o    = wipe_done_q;
  end

  // State, owner tag, sweep counter and response flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments here make every flop sample the
    // pre-edge values, whatever order the statements are written in.
    if (!rst_ni) begin
      state_q     <= ImemArbIdle;
      owner_q     <= OwnerNone;
      cnt_q       <= '0;
      wipe_done_q <= 1'b0;
      host_err_q  <= 1'b0;
      host_wack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      wipe_done_q <= wipe_done_d;
      host_err_q  <= host_err_d;
      host_wack_q <= host_wack_d;
    end
  end

endmodule

// File: tb/tb_otbn_imem_arbiter.sv
// Self-checking bench for otbn_imem_arbiter with a 64-byte IMEM (16 words).
module tb_otbn_imem_arbiter;

  localparam int Aw = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy = 1'b0, fatal = 1'b0, wipe_start = 1'b0;
  logic [38:0]   wipe_data = '0;
  logic          wipe_active, wipe_done, locked;
  logic          fetch_req = 1'b0;
  logic [Aw-1:0] fetch_addr = '0;
  logic          fetch_rvalid;
  logic [38:0]   fetch_rdata;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [Aw-1:0] host_addr = '0;
  logic [38:0]   host_wdata = '0;
  logic          host_gnt, host_rvalid, host_err;
  logic [38:0]   host_rdata;
  logic          mem_req, mem_we;
  logic [Aw-1:0] mem_addr;
  logic [38:0]   mem_wdata;
  logic [38:0]   mem_rdata;
  logic          mem_rvalid;

  int n_pass = 0;
  int n_total = 0;

  otbn_imem_arbiter #(.ImemSizeByte(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .busy_i(busy), .fatal_i(fatal),
    .wipe_start_i(wipe_start), .wipe_data_i(wipe_data),
    .wipe_active_o(wipe_active), .wipe_done_o(wipe_done), .locked_o(locked),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
    .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
    .host_rdata_o(host_rdata), .host_err_o(host_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid)
  );

  always #5 clk = ~clk;

  // IMEM stand-in: a read of address A returns 0x40_0000_0000 | A one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_rvalid <= mem_req && !mem_we;
      mem_rdata  <= (mem_req && !mem_we) ? (39'h40_0000_0000 | 39'(mem_addr)) : '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive_idle();
    busy = 1'b0; fatal = 1'b0; wipe_start = 1'b0; wipe_data = '0;
    fetch_req = 1'b0; fetch_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  typedef struct {
    logic        f_req;
    logic [5:0]  f_addr;
    logic        h_req;
    logic        h_we;
    logic [5:0]  h_addr;
    logic [38:0] h_wdata;
    logic        busy;
    logic        e_req;
    logic        e_we;
    logic [5:0]  e_addr;
    logic [38:0] e_wdata;
    logic        e_gnt;
    logic        e_frv;
    logic [38:0] e_frd;
    logic        e_hrv;
    logic        e_herr;
    logic [38:0] e_hrd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Fields: fetch req/addr, host req/we/addr/wdata, busy | mem req/we/addr/wdata,
    // gnt | next cycle: fetch rvalid/rdata, host rvalid/err/rdata
    vecs[0] = '{1'b1, 6'h10, 1'b1, 1'b0, 6'h20, 39'h0, 1'b0,
                1'b1, 1'b0, 6'h10, 39'h0, 1'b0,
                1'b1, 39'h40_0000_0010, 1'b0, 1'b0, 39'h0};
    vecs[1] = '{1'b0, 6'h00, 1'b1, 1'b0, 6'h20, 39'h0, 1'b0,
                1'b1, 1'b0, 6'h20, 39'h0, 1'b1,
                1'b0, 39'h0, 1'b1, 1'b0, 39'h40_0000_0020};
    vecs[2] = '{1'b0, 6'h00, 1'b1, 1'b0, 6'h30, 39'h0, 1'b1,
                1'b0, 1'b0, 6'h00, 39'h0, 1'b1,
                1'b0, 39'h0, 1'b1, 1'b1, 39'h0};
    vecs[3] = '{1'b0, 6'h00, 1'b1, 1'b1, 6'h08, 39'h1_2345_6789, 1'b0,
                1'b1, 1'b1, 6'h08, 39'h1_2345_6789, 1'b1,
                1'b0, 39'h0, 1'b1, 1'b0, 39'h0};
    vecs[4] = '{1'b1, 6'h13, 1'b0, 1'b0, 6'h00, 39'h0, 1'b0,
                1'b1, 1'b0, 6'h10, 39'h0, 1'b0,
                1'b1, 39'h40_0000_0010, 1'b0, 1'b0, 39'h0};
    vecs[5] = '{1'b1, 6'h2c, 1'b1, 1'b0, 6'h04, 39'h0, 1'b1,
                1'b1, 1'b0, 6'h2c, 39'h0, 1'b1,
                1'b1, 39'h40_0000_002c, 1'b1, 1'b1, 39'h0};
    vecs[6] = '{1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 39'h0, 1'b0,
                1'b0, 1'b0, 6'h00, 39'h0, 1'b0,
                1'b0, 39'h0, 1'b0, 1'b0, 39'h0};
    vecs[7] = '{1'b0, 6'h00, 1'b1, 1'b1, 6'h3f, 39'h7f_ffff_ffff, 1'b0,
                1'b1, 1'b1, 6'h3c, 39'h7f_ffff_ffff, 1'b1,
                1'b0, 39'h0, 1'b1, 1'b0, 39'h0};

    // Reset state
    drive_idle();
    #12;
    check("reset outputs a",
          {wipe_active, wipe_done, locked, fetch_rvalid, fetch_rdata, host_gnt, host_rvalid},
          '0);
    check("reset outputs b",
          {host_rdata, host_err, mem_req, mem_we, mem_addr, mem_wdata}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-transaction vectors in IDLE
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fetch_req = vecs[i].f_req;  fetch_addr = vecs[i].f_addr;
      host_req = vecs[i].h_req;   host_we = vecs[i].h_we;
      host_addr = vecs[i].h_addr; host_wdata = vecs[i].h_wdata;
      busy = vecs[i].busy;
      #1;
      check($sformatf("vec%0d request", i),
            {mem_req, mem_we, mem_addr, mem_wdata, host_gnt},
            {vecs[i].e_req, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_gnt});
      @(negedge clk);
      drive_idle();
      #1;
      check($sformatf("vec%0d response", i),
            {fetch_rvalid, fetch_rdata, host_rvalid, host_err, host_rdata},
            {vecs[i].e_frv, vecs[i].e_frd, vecs[i].e_hrv, vecs[i].e_herr, vecs[i].e_hrd});
    end

    // Full wipe sweep: 16 writes. A fetch is ignored and a restart request is
    // ignored. A host request gets an error response.
    @(negedge clk);
    wipe_start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wipe_start = (i == 4);
      fetch_req  = 1'b1;
      fetch_addr = 6'(i * 4);
      wipe_data  = 39'h7f_0000_0000 | 39'(i);
      host_req   = (i == 8);
      #1;
      check($sformatf("wipe word %0d", i),
            {mem_req, mem_we, mem_addr, mem_wdata, wipe_active, wipe_done, fetch_rvalid},
            {1'b1, 1'b1, 6'(i * 4), 39'h7f_0000_0000 | 39'(i), 1'b1, 1'b0, 1'b0});
      if (i == 8) check("wipe host gnt", host_gnt, 1'b1);
      if (i == 9) check("wipe host err rsp", {host_rvalid, host_err, host_rdata}, {1'b1, 1'b1, 39'h0});
    end
    @(negedge clk);
    drive_idle();
    #1;
    check("wipe done pulse", {wipe_done, wipe_active, mem_req, fetch_rvalid}, 4'b1000);
    @(negedge clk);
    #1;
    check("wipe done one cycle", {wipe_done, wipe_active}, 2'b00);

    // Reset in the middle of a sweep
    @(negedge clk);
    wipe_start = 1'b1;
    repeat (6) begin
      @(negedge clk);
      wipe_start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("reset mid-sweep a",
          {wipe_active, wipe_done, locked, fetch_rvalid, host_gnt, host_rvalid, host_err},
          '0);
    check("reset mid-sweep b", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wipe_start = 1'b1;
    @(negedge clk);
    wipe_start = 1'b0;
    #1;
    check("restart sweep from word 0", {wipe_active, mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 1'b1, 6'h00});
    repeat (17) @(negedge clk);
    #1;
    check("restart sweep finished", {wipe_active, locked}, 2'b00);

    // Fatal error at sweep word 5
    @(negedge clk);
    wipe_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wipe_start = 1'b0;
      fatal = (i == 5);
    end
    #1;
    check("fatal cycle addr", {mem_req, mem_addr}, {1'b1, 6'h14});
    @(negedge clk);
    fatal = 1'b0;
    #1;
    check("locked after fatal", {mem_req, locked, wipe_active}, 3'b010);
    begin
      logic saw_done;
      saw_done = wipe_done;
      repeat (14) begin
        @(negedge clk);
        #1;
        saw_done = saw_done | wipe_done;
      end
      check("no wipe_done after fatal", saw_done, 1'b0);
    end
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 6'h08; host_wdata = 39'h1_2345_6789;
    fetch_req = 1'b1; fetch_addr = 6'h10;
    #1;
    check("locked host gnt, no mem", {host_gnt, mem_req, locked}, 3'b101);
    @(negedge clk);
    drive_idle();
    #1;
    check("locked host err rsp", {host_rvalid, host_err, host_rdata, fetch_rvalid},
          {1'b1, 1'b1, 39'h0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
